// File: rtl/restoreone.sv
// restoreone: rebuilds a right-justified mantissa from a left-aligned fraction
// (hidden one stripped) and the leading-one position, shifting in one fraction
// bit per clock. Inverse of the FP adder's leading-one normaliser.
// Optional feature: define RESTOREONE_STICKY_EN to add the 'sticky' output
// (OR of the fraction bits that were not consumed into the mantissa).
module restoreone #(
  parameter int WIDTH = 32,
  parameter int POSW  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] frac,
  input  logic [POSW-1:0]  pos,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mant,
  output logic             err,
  output logic             busy
`ifdef RESTOREONE_STICKY_EN
  ,
  output logic             sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  sh_q;
  logic [WIDTH-1:0]  acc_q;
  logic [POSW-1:0]   cnt_q;
  logic              err_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;
`ifdef RESTOREONE_STICKY_EN
  logic              sticky_q;
`endif

  // Next values of the shift datapath for one SHIFT step.
  logic [WIDTH-1:0]  sh_d;
  logic [WIDTH-1:0]  acc_d;
  logic [POSW-1:0]   cnt_d;
  logic [31:0]       pos_ext;
  logic              pos_bad;
  logic              cnt_last;

  // Combinational helpers: the next shift step and operand classification.
  always_comb begin
    sh_d     = sh_q << 1;
    acc_d    = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
    cnt_d    = cnt_q - POSW'(1);
    pos_ext  = 32'(pos);
    pos_bad  = (pos_ext >= 32'(WIDTH));
    cnt_last = (cnt_q == POSW'(1));
  end

  // Control FSM and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RESTOREONE_STICKY_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q       <= frac;
            acc_q      <= WIDTH'(1);
            cnt_q      <= pos;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            if (in_zero) begin
              acc_q       <= '0;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
`ifdef RESTOREONE_STICKY_EN
              sticky_q    <= 1'b0;
`endif
            end else if (pos_bad) begin
              acc_q       <= '0;
              err_q       <= 1'b1;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
`ifdef RESTOREONE_STICKY_EN
              sticky_q    <= 1'b0;
`endif
            end else if (pos == '0) begin
              // Hidden one alone is the mantissa; every fraction bit is left over.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
`ifdef RESTOREONE_STICKY_EN
              sticky_q    <= |frac;
`endif
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
            end
          end
        end

        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_d;
          if (cnt_last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef RESTOREONE_STICKY_EN
            // Whatever remains in the shifter after the last step was not consumed.
            sticky_q    <= |sh_d;
`endif
          end
        end

        DONE: begin
          // Result held until the consumer takes it; no new operand on this edge.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign mant      = acc_q;
  assign err       = err_q;
  assign busy      = busy_q;
`ifdef RESTOREONE_STICKY_EN
  assign sticky    = sticky_q;
`endif

endmodule
